multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Control FSM for the multicycle RV32I core.
- Generates the per-cycle write_enable strobes for the downstream single_register instances (PC, IR, MDR, ALU-out) and the register file.
- Sequences memory read/write requests with a ready handshake.
- Sits between the instruction/memory interface and the datapath registers. It is the only block that advances architectural state.

Parameters:
- OPCODE_WIDTH, 7, width of the opcode field taken from the IR.

Ports:
- clock  input  1  global clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- opcode  input  OPCODE_WIDTH  inst[6:0] from the IR register output
- mem_ready  input  1  memory completes the current request this cycle
- state  output  3  current FSM state (debug/observability)
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- pc_write_enable  output  1  PC register write strobe
- ir_write_enable  output  1  IR register write strobe
- mdr_write_enable  output  1  MDR register write strobe
- alu_out_write_enable  output  1  ALU-out register write strobe
- regfile_write_enable  output  1  register file write strobe
- illegal_instruction  output  1  one-cycle pulse on an unknown opcode

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM_ACCESS=3, WRITEBACK=4. Encodings 5-7 are unreachable; if ever entered, go to FETCH with all outputs 0.
- The state register resets asynchronously to FETCH. While reset_n=0, every output is forced to 0 (state reads 0).
- All strobes are combinational from (state, opcode, mem_ready). Strobes take effect at the next rising edge.
- FETCH:
  - mem_read=1.
  - mem_ready=0: stay in FETCH.
  - mem_ready=1: ir_write_enable=1, go to DECODE.
- DECODE: alu_out_write_enable=1 (branch target precompute), go to EXECUTE.
- EXECUTE: alu_out_write_enable=1. Next state by opcode:
  - LOAD 0000011, STORE 0100011: go to MEM_ACCESS.
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111: go to WRITEBACK.
  - BRANCH 1100011: pc_write_enable=1, go to FETCH. The datapath selects the target or PC+4.
  - MISC-MEM 0001111, SYSTEM 1110011: treated as NOP. pc_write_enable=1, go to FETCH.
  - Any other opcode: illegal_instruction=1, pc_write_enable=1, go to FETCH. No other strobe.
- MEM_ACCESS:
  - LOAD: mem_read=1. On mem_ready, mdr_write_enable=1 and go to WRITEBACK.
  - STORE: mem_write=1. On mem_ready, pc_write_enable=1 and go to FETCH.
  - mem_ready=0: hold state, request stays asserted.
  - The request must remain stable (no deassert) until mem_ready.
- WRITEBACK: regfile_write_enable=1, pc_write_enable=1, go to FETCH.
- mem_read and mem_write are never both 1.
- At most one of ir/mdr write enables per cycle.
- Latency per instruction, with zero memory wait:
  - BRANCH/NOP/illegal: 3 cycles.
  - ALU/jump: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- mem_ready outside FETCH/MEM_ACCESS is ignored.
- opcode is sampled only in EXECUTE/MEM_ACCESS. The IR is stable there because ir_write_enable is only asserted in FETCH.
- Reset asserted mid-operation: immediate return to FETCH, outputs 0, no partial strobe. After release, the first active cycle is FETCH with mem_read=1.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_INSTRET_EN.
- When defined:
  - Adds output instret (64-bit), reset to 0 asynchronously.
  - Increments by 1 on each rising edge where pc_write_enable=1, including illegal/NOP retirement.
  - Wraps from 2^64-1 to 0.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then OP-IMM opcode 0010011 with mem_ready=1 constantly -> states 0,1,2,4,0. ir_we in cycle 1, regfile_we+pc_we in cycle 4. instret=1.
- LOAD 0000011; mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_ACCESS -> mem_read held continuously during waits. mdr_we only on the ready cycle. Total 10 cycles to return to FETCH.
- STORE 0100011, mem_ready=1 -> mem_write=1 only in MEM_ACCESS. No regfile_we. pc_we in cycle 4. mem_read never 1 in MEM_ACCESS.
- BRANCH 1100011 then opcode 1111111 -> branch retires in 3 cycles with pc_we. Illegal opcode pulses illegal_instruction for exactly 1 cycle with pc_we, then FETCH.
- Assert reset_n=0 asynchronously mid-MEM_ACCESS (LOAD, waiting) -> all outputs 0 within the same cycle, state=0. After release, mem_read=1 and FETCH proceeds. instret=0.
- With the macro: preload instret near the wrap (force 2^64-1), retire one instruction -> instret=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/mem/writeback
// and emits register write strobes. Optional MULTICYCLE_CONTROL_INSTRET_EN adds instret.
module multicycle_control #(
  parameter int OPCODE_WIDTH = 7
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  output logic [2:0]              state,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    pc_write_enable,
  output logic                    ir_write_enable,
  output logic                    mdr_write_enable,
  output logic                    alu_out_write_enable,
  output logic                    regfile_write_enable,
  output logic                    illegal_instruction
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
  ,
  output logic [63:0]             instret
`endif
);

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    DECODE     = 3'd1,
    EXECUTE    = 3'd2,
    MEM_ACCESS = 3'd3,
    WRITEBACK  = 3'd4
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_OP     = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_IMM    = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI    = OPCODE_WIDTH'(7'b0110111);
  localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC  = OPCODE_WIDTH'(7'b0010111);
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = OPCODE_WIDTH'(7'b1101111);
  localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = OPCODE_WIDTH'(7'b1100111);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = OPCODE_WIDTH'(7'b1100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_MISC   = OPCODE_WIDTH'(7'b0001111);
  localparam logic [OPCODE_WIDTH-1:0] OP_SYSTEM = OPCODE_WIDTH'(7'b1110011);

  state_t cur, nxt;

  logic is_load, is_store, is_mem, is_wb, is_ret;
  logic rd_c, wr_c, pc_c, ir_c, mdr_c, alu_c, rf_c, ill_c;

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = is_load | is_store;
  assign is_wb    = (opcode == OP_OP)    | (opcode == OP_IMM)
                  | (opcode == OP_LUI)   | (opcode == OP_AUIPC)
                  | (opcode == OP_JAL)   | (opcode == OP_JALR);
  assign is_ret   = (opcode == OP_BRANCH) | (opcode == OP_MISC)
                  | (opcode == OP_SYSTEM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cur <= FETCH;
    else          cur <= nxt;
  end

  always_comb begin
    nxt   = FETCH;
    rd_c  = 1'b0;
    wr_c  = 1'b0;
    pc_c  = 1'b0;
    ir_c  = 1'b0;
    mdr_c = 1'b0;
    alu_c = 1'b0;
    rf_c  = 1'b0;
    ill_c = 1'b0;
    case (cur)
      FETCH: begin
        rd_c = 1'b1;
        if (mem_ready) begin
          ir_c = 1'b1;
          nxt  = DECODE;
        end else begin
          nxt  = FETCH;
        end
      end
      DECODE: begin
        alu_c = 1'b1;
        nxt   = EXECUTE;
      end
      EXECUTE: begin
        unique case (1'b1)
          is_mem: begin
            alu_c = 1'b1;
            nxt   = MEM_ACCESS;
          end
          is_wb: begin
            alu_c = 1'b1;
            nxt   = WRITEBACK;
          end
          is_ret: begin
            alu_c = 1'b1;
            pc_c  = 1'b1;
            nxt   = FETCH;
          end
          default: begin
            ill_c = 1'b1;
            pc_c  = 1'b1;
            nxt   = FETCH;
          end
        endcase
      end
      MEM_ACCESS: begin
        if (is_load) begin
          rd_c = 1'b1;
          if (mem_ready) begin
            mdr_c = 1'b1;
            nxt   = WRITEBACK;
          end else begin
            nxt   = MEM_ACCESS;
          end
        end else if (is_store) begin
          wr_c = 1'b1;
          if (mem_ready) begin
            pc_c = 1'b1;
            nxt  = FETCH;
          end else begin
            nxt  = MEM_ACCESS;
          end
        end else begin
          // IR cannot change here; retire defensively rather than hang
          pc_c = 1'b1;
          nxt  = FETCH;
        end
      end
      WRITEBACK: begin
        rf_c = 1'b1;
        pc_c = 1'b1;
        nxt  = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end

  // Reset masks every output so nothing leaks while reset_n is low
  assign state                = reset_n ? cur : 3'd0;
  assign mem_read             = reset_n & rd_c;
  assign mem_write            = reset_n & wr_c;
  assign pc_write_enable      = reset_n & pc_c;
  assign ir_write_enable      = reset_n & ir_c;
  assign mdr_write_enable     = reset_n & mdr_c;
  assign alu_out_write_enable = reset_n & alu_c;
  assign regfile_write_enable = reset_n & rf_c;
  assign illegal_instruction  = reset_n & ill_c;

`ifdef MULTICYCLE_CONTROL_INSTRET_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)             instret <= 64'd0;
    else if (pc_write_enable) instret <= instret + 64'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle traces built
// from instruction class and wait counts, random opcodes and waits.
module tb_multicycle_control;

  logic       clock;
  logic       reset_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic [2:0] state;
  logic       mem_read, mem_write, pc_write_enable, ir_write_enable;
  logic       mdr_write_enable, alu_out_write_enable;
  logic       regfile_write_enable, illegal_instruction;
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
  logic [63:0] instret;
`endif

  multicycle_control #(.OPCODE_WIDTH(7)) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .opcode               (opcode),
    .mem_ready            (mem_ready),
    .state                (state),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .pc_write_enable      (pc_write_enable),
    .ir_write_enable      (ir_write_enable),
    .mdr_write_enable     (mdr_write_enable),
    .alu_out_write_enable (alu_out_write_enable),
    .regfile_write_enable (regfile_write_enable),
    .illegal_instruction  (illegal_instruction)
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    ,
    .instret              (instret)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [63:0] model_instret = 64'd0;

  // strobe vector: {rd, wr, pc, ir, mdr, alu, rf, ill}
  localparam logic [7:0] S_RD  = 8'h80;
  localparam logic [7:0] S_WR  = 8'h40;
  localparam logic [7:0] S_PC  = 8'h20;
  localparam logic [7:0] S_IR  = 8'h10;
  localparam logic [7:0] S_MDR = 8'h08;
  localparam logic [7:0] S_ALU = 8'h04;
  localparam logic [7:0] S_RF  = 8'h02;
  localparam logic [7:0] S_ILL = 8'h01;

  typedef struct {
    logic [2:0] st;
    logic       rdy;
    logic [7:0] o;
  } cyc_t;

  cyc_t exp_q[$];

  logic [6:0] legal_ops [12] = '{
    7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
    7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
    7'b1100011, 7'b0001111, 7'b1110011, 7'b0110011
  };

  function automatic logic [7:0] obs_vec();
    return {mem_read, mem_write, pc_write_enable, ir_write_enable,
            mdr_write_enable, alu_out_write_enable,
            regfile_write_enable, illegal_instruction};
  endfunction

  function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  // 0 load, 1 store, 2 writeback class, 3 branch/nop, 4 illegal
  function automatic int op_class(logic [6:0] op);
    case (op)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011, 7'b0010011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: return 2;
      7'b1100011, 7'b0001111, 7'b1110011: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic void push(logic [2:0] st, logic rdy, logic [7:0] o);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.o = o;
    exp_q.push_back(c);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  function automatic void build(logic [6:0] op, int fw, int mw);
    int c = op_class(op);
    exp_q.delete();
    for (int i = 0; i < fw; i++) push(3'd0, 1'b0, S_RD);
    push(3'd0, 1'b1, S_RD | S_IR);
    push(3'd1, rnd_bit(), S_ALU);
    case (c)
      0, 1: begin
        logic [7:0] req = (c == 0) ? S_RD : S_WR;
        push(3'd2, rnd_bit(), S_ALU);
        for (int i = 0; i < mw; i++) push(3'd3, 1'b0, req);
        push(3'd3, 1'b1, req | ((c == 0) ? S_MDR : S_PC));
        if (c == 0) push(3'd4, rnd_bit(), S_RF | S_PC);
      end
      2: begin
        push(3'd2, rnd_bit(), S_ALU);
        push(3'd4, rnd_bit(), S_RF | S_PC);
      end
      3: push(3'd2, rnd_bit(), S_ALU | S_PC);
      default: push(3'd2, rnd_bit(), S_ILL | S_PC);
    endcase
  endfunction

  task automatic expect_reset_quiet(string tag);
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_outs"}, 64'(obs_vec()), 64'd0);
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    chk({tag, "_instret"}, instret, 64'd0);
`endif
  endtask

  // Release reset at a negedge; that cycle is an extra fetch wait
  task automatic release_reset();
    @(negedge clock);
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("post_reset_state", 64'(state), 64'd0);
    chk("post_reset_outs", 64'(obs_vec()), 64'(S_RD));
  endtask

  task automatic run(string tag, logic [6:0] op, int fw, int mw, int abort_at);
    build(op, fw, mw);
    foreach (exp_q[i]) begin
      @(negedge clock);
      opcode    = op;
      mem_ready = exp_q[i].rdy;
      #1;
      chk({tag, "_state"}, 64'(state), 64'(exp_q[i].st));
      chk({tag, "_strobes"}, 64'(obs_vec()), 64'(exp_q[i].o));
      chk({tag, "_rdwr_excl"}, 64'(mem_read & mem_write), 64'd0);
      chk({tag, "_irmdr_excl"}, 64'(ir_write_enable & mdr_write_enable), 64'd0);
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
      chk({tag, "_instret"}, instret, model_instret);
`endif
      if (i == abort_at) begin
        #1 reset_n = 1'b0;
        #1;
        expect_reset_quiet({tag, "_async"});
        model_instret = 64'd0;
        @(negedge clock);
        expect_reset_quiet({tag, "_held"});
        break;
      end
      if ((exp_q[i].o & S_PC) != 8'h00) model_instret++;
    end
  endtask

  initial begin
    logic [6:0] op;
    reset_n   = 1'b0;
    opcode    = 7'd0;
    mem_ready = 1'b1;
    #3;
    expect_reset_quiet("reset_pre_edge");
    #4;
    expect_reset_quiet("reset_post_edge");
    release_reset();

    run("opimm", 7'b0010011, 0, 0, -1);
    run("load_waits", 7'b0000011, 2, 3, -1);
    run("store", 7'b0100011, 0, 0, -1);
    run("branch", 7'b1100011, 0, 0, -1);
    run("illegal", 7'b1111111, 0, 0, -1);
    run("fence", 7'b0001111, 1, 0, -1);
    run("store_waits", 7'b0100011, 0, 2, -1);

    run("load_reset", 7'b0000011, 0, 3, 4);
    reset_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("mid_reset_fetch_state", 64'(state), 64'd0);
    chk("mid_reset_fetch_outs", 64'(obs_vec()), 64'(S_RD));
    run("after_reset", 7'b0110111, 0, 0, -1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) op = 7'($urandom);
      else op = legal_ops[$urandom_range(0, 11)];
      run("rand", op, $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    @(posedge clock);
    #1;
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    model_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    run("wrap", 7'b0010011, 0, 0, -1);
    @(posedge clock);
    #1;
    chk("instret_wrap", instret, model_instret);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
